// File: rtl/code_lock_checker.sv
// Code lock checker: registers the switch-entry digit stream, compares completed codes to a stored key,
// and drives unlock/fail/program indications. Optional lockout after repeated failures: CODE_LOCK_LOCKOUT_EN.
module code_lock_checker #(
  parameter logic [15:0] KEY_INIT       = 16'h4321,
  parameter logic [31:0] OPEN_CYCLES    = 32'd100000000,
  parameter logic [31:0] FAIL_CYCLES    = 32'd50000000,
  parameter logic [1:0]  MAX_FAIL       = 2'd3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd500000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] Code,
  input  logic [2:0]  Code_Bit,
  input  logic        Prog,
  output logic        Unlock,
  output logic        Fail,
  output logic        Prog_Mode,
  output logic        Lockout,
  output logic [1:0]  Fail_Cnt,
  output logic [2:0]  State
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;
  localparam logic [2:0] S_REARM = 3'd5;
  localparam logic [2:0] S_PROG  = 3'd6;
  localparam logic [2:0] S_LOCK  = 3'd7;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  logic [15:0] r_code_q;
  logic [2:0]  r_cb_q;
  logic        r_prog_q;
  logic        r_prog_d;
  logic        r_full_d;
  logic [2:0]  r_state;
  logic [15:0] r_key;
  logic [1:0]  r_fail_cnt;
  logic [31:0] r_timer;
  logic        r_arm;
  logic        r_unlock;
  logic        r_fail;
  logic        r_prog_mode;

  logic        w_full;
  logic        w_full_rise;
  logic        w_prog_rise;
  logic        w_timer_zero;
  logic [2:0]  w_next;
  logic        w_key_wr;
  logic [1:0]  w_fail_cnt_nxt;
  logic [31:0] w_timer_nxt;
  logic        w_arm_nxt;
  logic        w_unlock_nxt;
  logic        w_fail_nxt;
  logic        w_prog_mode_nxt;

  assign w_full       = (r_cb_q >= 3'd4);
  assign w_full_rise  = w_full & ~r_full_d;
  assign w_prog_rise  = r_prog_q & ~r_prog_d;
  assign w_timer_zero = (r_timer == 32'd0);

  // Every decision below works from these single-registered copies of the inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_code_q <= 16'd0;
      r_cb_q   <= 3'd0;
      r_prog_q <= 1'b0;
      r_prog_d <= 1'b0;
      r_full_d <= 1'b0;
    end else begin
      r_code_q <= Code;
      r_cb_q   <= Code_Bit;
      r_prog_q <= Prog;
      r_prog_d <= r_prog_q;
      r_full_d <= w_full;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_key       <= KEY_INIT;
      r_fail_cnt  <= 2'd0;
      r_timer     <= 32'd0;
      r_arm       <= 1'b0;
      r_unlock    <= 1'b0;
      r_fail      <= 1'b0;
      r_prog_mode <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fail_cnt  <= w_fail_cnt_nxt;
      r_timer     <= w_timer_nxt;
      r_arm       <= w_arm_nxt;
      r_unlock    <= w_unlock_nxt;
      r_fail      <= w_fail_nxt;
      r_prog_mode <= w_prog_mode_nxt;
      if (w_key_wr) r_key <= r_code_q;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_key_wr       = 1'b0;
    w_fail_cnt_nxt = r_fail_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_full_rise)                   w_next = S_CHECK;
        else if (!w_full && r_cb_q != 3'd0) w_next = S_ENTRY;
      end
      S_ENTRY: begin
        if (r_cb_q == 3'd0)   w_next = S_IDLE;
        else if (w_full_rise) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (r_code_q == r_key) begin
          w_next         = S_OPEN;
          w_fail_cnt_nxt = 2'd0;
        end else begin
          w_next         = S_FAIL;
          w_fail_cnt_nxt = (r_fail_cnt == 2'd3) ? 2'd3 : r_fail_cnt + 2'd1;
        end
      end
      S_OPEN: begin
        if (w_prog_rise)       w_next = S_PROG;
        else if (w_timer_zero) w_next = S_REARM;
      end
      S_FAIL: begin
        if (w_timer_zero)
          w_next = (LOCK_EN && r_fail_cnt == MAX_FAIL) ? S_LOCK : S_REARM;
      end
      S_REARM: begin
        if (r_cb_q == 3'd0) w_next = S_IDLE;
      end
      S_PROG: begin
        // Abort wins over a simultaneous armed write so the key is never half-committed.
        if (w_prog_rise) begin
          w_next = S_REARM;
        end else if (r_arm && w_full_rise) begin
          w_key_wr = 1'b1;
          w_next   = S_REARM;
        end
      end
      S_LOCK: begin
        if (w_timer_zero) begin
          w_fail_cnt_nxt = 2'd0;
          w_next         = S_REARM;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Timer reloads with N-1 on entry so the timed state lasts exactly N cycles.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_next != r_state) begin
      case (w_next)
        S_OPEN:  w_timer_nxt = OPEN_CYCLES - 32'd1;
        S_FAIL:  w_timer_nxt = FAIL_CYCLES - 32'd1;
        S_LOCK:  w_timer_nxt = LOCKOUT_CYCLES - 32'd1;
        default: w_timer_nxt = 32'd0;
      endcase
    end else if (!w_timer_zero) begin
      w_timer_nxt = r_timer - 32'd1;
    end
  end

  always_comb begin
    w_arm_nxt = r_arm;
    if (w_next == S_PROG && r_state != S_PROG) w_arm_nxt = 1'b0;
    else if (r_state == S_PROG && r_cb_q == 3'd0) w_arm_nxt = 1'b1;
  end

  always_comb begin
    w_unlock_nxt    = (w_next == S_OPEN);
    w_fail_nxt      = (w_next == S_FAIL);
    w_prog_mode_nxt = (w_next == S_PROG);
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  logic r_lockout;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_lockout <= 1'b0;
    else     r_lockout <= (w_next == S_LOCK);
  end
  assign Lockout = r_lockout;
`else
  assign Lockout = 1'b0;
`endif

  assign Unlock    = r_unlock;
  assign Fail      = r_fail;
  assign Prog_Mode = r_prog_mode;
  assign Fail_Cnt  = r_fail_cnt;
  assign State     = r_state;

endmodule

// File: tb/tb_code_lock_checker.sv
// Bench for code_lock_checker: directed scenarios plus random code attempts against a key/fail-count model.
module tb_code_lock_checker;

  localparam int          OPEN_N = 8;
  localparam int          FAIL_N = 4;
  localparam logic [15:0] KEY0   = 16'h4321;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_ENTRY = 3'd1;
  localparam logic [2:0]  ST_CHECK = 3'd2;
  localparam logic [2:0]  ST_REARM = 3'd5;
  localparam logic [2:0]  ST_PROG  = 3'd6;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int LOCK_N = 16;
  localparam int MAX_F  = 3;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] code;
  logic [2:0]  cb;
  logic        prog;
  logic        Unlock, Fail, Prog_Mode, Lockout;
  logic [1:0]  Fail_Cnt;
  logic [2:0]  State;

  always #5 clk = ~clk;

  code_lock_checker #(
    .KEY_INIT(16'h4321), .OPEN_CYCLES(32'd8), .FAIL_CYCLES(32'd4),
    .MAX_FAIL(2'd3), .LOCKOUT_CYCLES(32'd16)
  ) dut (
    .CLK(clk), .RST(rst), .Code(code), .Code_Bit(cb), .Prog(prog),
    .Unlock(Unlock), .Fail(Fail), .Prog_Mode(Prog_Mode), .Lockout(Lockout),
    .Fail_Cnt(Fail_Cnt), .State(State)
  );

  // scoreboard / model
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_key;
  int          m_fail;
  logic [3:0]  exp_q[$];
  bit          e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: step digits, then go full; returns on the edge the outcome should appear
  task automatic start_entry(input logic [15:0] c, input int pre, output bit exp_open);
    logic [3:0] ex;
    code = c;
    for (int i = 1; i <= pre; i++) begin
      cb = i[2:0];
      tick();
    end
    cb = 3'($urandom_range(4, 7));
    exp_open = (c == m_key);
    if (exp_open) m_fail = 0;
    else if (m_fail < 3) m_fail++;
    exp_q.push_back({exp_open, !exp_open, m_fail[1:0]});
    tick();
    tick();
    check("check_state", State, ST_CHECK);
    check("pre_outputs", {Unlock, Fail}, 2'b00);
    tick();
    ex = exp_q.pop_front();
    check("outcome", {Unlock, Fail, Fail_Cnt}, ex);
  endtask

  task automatic finish_entry(input bit exp_open);
    int hi;
    bit saw;
    hi = 0;
    saw = 1'b0;
    while ((exp_open ? Unlock : Fail) === 1'b1 && hi < 1000) begin
      hi++;
      tick();
    end
    check(exp_open ? "unlock_width" : "fail_width", hi, exp_open ? OPEN_N : FAIL_N);
`ifdef CODE_LOCK_LOCKOUT_EN
    if (!exp_open && m_fail == MAX_F) begin
      hi = 0;
      while (Lockout === 1'b1 && hi < 1000) begin
        if (hi == 3) cb = 3'd0;
        if (hi == 6) begin
          code = m_key;
          cb = 3'd4;
        end
        saw |= Unlock;
        hi++;
        tick();
      end
      check("lock_width", hi, LOCK_N);
      check("lock_ignores_code", saw, 1'b0);
      m_fail = 0;
    end
`endif
    check("lockout_off", Lockout, 1'b0);
    check("rearm_state", State, ST_REARM);
    check("rearm_cnt", Fail_Cnt, m_fail);
    tick();
    check("stale_full_hold", State, ST_REARM);
    cb = 3'd0;
    tick();
    tick();
    check("back_idle", State, ST_IDLE);
  endtask

  task automatic enter_prog();
    prog = 1'b1;
    tick();
    prog = 1'b0;
    tick();
    check("prog_mode", Prog_Mode, 1'b1);
    check("prog_state", State, ST_PROG);
    check("prog_unlock_off", Unlock, 1'b0);
  endtask

  task automatic release_reset();
    cb = 3'd0;
    code = 16'd0;
    prog = 1'b0;
    tick();
    rst = 1'b0;
    m_key = KEY0;
    m_fail = 0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    code = 16'd0;
    cb = 3'd0;
    prog = 1'b0;
    #1;
    tick();
    check("rst_outputs", {Unlock, Fail, Prog_Mode, Lockout}, 4'b0000);
    check("rst_cnt_state", {Fail_Cnt, State}, 5'd0);
    release_reset();

    // correct code, then wrong codes up to and past saturation / lockout
    start_entry(KEY0, 3, e);
    finish_entry(e);
    start_entry(16'h1111, 0, e);
    finish_entry(e);
    repeat (3) begin
      start_entry(16'h2222, $urandom_range(0, 3), e);
      finish_entry(e);
    end

    // partial entry abandoned
    cb = 3'd2;
    tick();
    tick();
    check("entry_state", State, ST_ENTRY);
    cb = 3'd0;
    tick();
    tick();
    check("abort_idle", State, ST_IDLE);
    check("abort_cnt", Fail_Cnt, m_fail);

    // key reprogramming, early full entry ignored until emptied
    start_entry(m_key, 2, e);
    enter_prog();
    cb = 3'd3;
    tick();
    tick();
    code = 16'h0987;
    cb = 3'd4;
    repeat (3) tick();
    check("prog_unarmed_hold", {Prog_Mode, State}, {1'b1, ST_PROG});
    cb = 3'd0;
    tick();
    tick();
    cb = 3'd4;
    tick();
    tick();
    check("prog_write_exit", {Prog_Mode, State}, {1'b0, ST_REARM});
    m_key = 16'h0987;
    cb = 3'd0;
    tick();
    tick();
    start_entry(KEY0, 1, e);
    finish_entry(e);
    start_entry(16'h0987, 0, e);
    finish_entry(e);

    // program abort leaves key alone
    start_entry(m_key, 0, e);
    enter_prog();
    prog = 1'b1;
    tick();
    tick();
    prog = 1'b0;
    check("prog_abort", {Prog_Mode, State}, {1'b0, ST_REARM});
    cb = 3'd0;
    tick();
    tick();
    start_entry(16'h0987, 2, e);
    finish_entry(e);

    // random attempts
    repeat (24) begin
      logic [15:0] c;
      c = ($urandom_range(0, 2) == 0) ? m_key : 16'($urandom);
      start_entry(c, $urandom_range(0, 3), e);
      finish_entry(e);
    end

    // asynchronous reset mid-FAIL and mid-OPEN
    start_entry(~m_key, 0, e);
    rst = 1'b1;
    #1;
    check("rst_async_fail", {Fail, Fail_Cnt, State}, 6'd0);
    release_reset();
    start_entry(16'h0987, 0, e);
    finish_entry(e);
    start_entry(KEY0, 3, e);
    tick();
    rst = 1'b1;
    #1;
    check("rst_async_open", {Unlock, Fail_Cnt, State}, 6'd0);
    release_reset();
    start_entry(KEY0, 0, e);
    finish_entry(e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
